rocc_resp_tracker: RTL

// - Downstream companion of the RoCC command adapter: records every RoCC command with xd=1 that fires
//   (trans_id, rd), then matches accelerator responses back to the issuing scoreboard trans_id.
// - Drives one registered writeback port into the Ariane commit/scoreboard path.
// - Absorbs responses for commands killed by a flush.
// - Bounds total outstanding RoCC work to DEPTH via alloc_ready_o, which gates issue.

---
 rtl/rocc_resp_tracker_pkg.sv | 39 +++
 rtl/rocc_resp_tracker_if.sv | 36 +++
 rtl/rocc_resp_tracker_tag_fifo.sv | 68 ++++++
 rtl/rocc_resp_tracker.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/rocc_resp_tracker_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : rocc_resp_tracker_pkg
// Brief   : Shared types and RoCC instruction field helpers for the tracker.
// Revision: 1.0
// ============================================================================
package rocc_resp_tracker_pkg;

  localparam int TRANS_ID_BITS = 3;
  localparam int ROCC_XD_BIT   = 14;
  localparam int ROCC_RD_LSB   = 7;
  localparam int ROCC_RD_W     = 5;

  typedef struct packed {
    logic [ROCC_RD_W-1:0] resp_rd;
    logic [63:0]          resp_data;
  } rocc_resp_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] cause;
  } exception_t;

  typedef struct packed {
    logic [TRANS_ID_BITS-1:0] trans_id;
    logic [ROCC_RD_W-1:0]     rd;
  } tag_t;

  function automatic logic rocc_xd(input logic [31:0] instr);
    return instr[ROCC_XD_BIT];
  endfunction

  function automatic logic [ROCC_RD_W-1:0] rocc_rd(input logic [31:0] instr);
    return instr[ROCC_RD_LSB +: ROCC_RD_W];
  endfunction

endpackage
`default_nettype wire

// File: rtl/rocc_resp_tracker_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : rocc_resp_tracker_if
// Brief   : Command-observe, response and writeback bundle of the tracker.
// Revision: 1.0
// ============================================================================
interface rocc_resp_tracker_if;
  import rocc_resp_tracker_pkg::*;

  logic                     cmd_fire_i;
  logic [TRANS_ID_BITS-1:0] cmd_trans_id_i;
  logic [31:0]              cmd_instr_i;
  logic                     alloc_ready_o;
  rocc_resp_t               rocc_resp_i;
  logic                     rocc_resp_valid_i;
  logic                     rocc_resp_ready_o;
  logic                     wb_valid_o;
  logic [TRANS_ID_BITS-1:0] wb_trans_id_o;
  logic [63:0]              wb_result_o;
  exception_t               wb_exception_o;

  modport slave (
    input  cmd_fire_i, cmd_trans_id_i, cmd_instr_i, rocc_resp_i, rocc_resp_valid_i,
    output alloc_ready_o, rocc_resp_ready_o, wb_valid_o, wb_trans_id_o, wb_result_o,
           wb_exception_o
  );

  modport master (
    output cmd_fire_i, cmd_trans_id_i, cmd_instr_i, rocc_resp_i, rocc_resp_valid_i,
    input  alloc_ready_o, rocc_resp_ready_o, wb_valid_o, wb_trans_id_o, wb_result_o,
           wb_exception_o
  );

endinterface
`default_nettype wire

// File: rtl/rocc_resp_tracker_tag_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : rocc_resp_tracker_tag_fifo
// Brief   : Tag FIFO of {trans_id, rd}; push/pop/clear, occupancy counter.
// Revision: 1.0
// ============================================================================
module rocc_resp_tracker_tag_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  wire logic             clk_i,
  input  wire logic             rst_ni,
  input  wire logic             i_push,
  input  wire logic             i_pop,
  input  wire logic             i_clear,
  input  wire logic [W-1:0]     i_wdata,
  output logic      [W-1:0]     o_head,
  output logic      [CNT_W-1:0] o_count,
  output logic                  o_full,
  output logic                  o_empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

  // A pop frees the head slot, so a full FIFO may still accept a push that cycle.
  assign w_pop  = i_pop & ~o_empty;
  assign w_push = i_push & (~o_full | w_pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push && !i_clear) r_mem[r_wr_ptr] <= i_wdata;
  end

endmodule
`default_nettype wire

// File: rtl/rocc_resp_tracker.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : rocc_resp_tracker
// Brief   : Matches RoCC responses to issuing trans_ids, drains flushed work.
// Revision: 1.0
// ============================================================================
module rocc_resp_tracker
  import rocc_resp_tracker_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  wire logic             clk_i,
  input  wire logic             rst_ni,
  input  wire logic             flush_i,
  rocc_resp_tracker_if.slave    bus,
  output logic      [CNT_W-1:0] outstanding_o,
  output logic                  drain_busy_o,
  output logic                  rd_mismatch_o
);

  localparam int TAG_W = TRANS_ID_BITS + ROCC_RD_W;

  tag_t                     w_head;
  tag_t                     w_push_tag;
  logic [CNT_W-1:0]         w_count;
  logic                     w_full;
  logic                     w_empty;
  logic [CNT_W:0]           w_total;
  logic                     w_alloc_ready;
  logic                     w_push_req;
  logic                     w_push;
  logic                     w_resp_fire;
  logic                     w_draining;
  logic                     w_rd_hit;
  logic                     w_fifo_push;
  logic                     w_fifo_pop;
  logic                     w_wb_fire;
  logic                     w_mismatch;
  logic [CNT_W-1:0]         w_debt;
  logic [CNT_W-1:0]         w_drain_d;

  logic [CNT_W-1:0]         r_drain;
  logic                     r_wb_valid;
  logic [TRANS_ID_BITS-1:0] r_wb_trans_id;
  logic [63:0]              r_wb_result;
  logic                     r_mismatch;

  assign w_push_tag.trans_id = bus.cmd_trans_id_i;
  assign w_push_tag.rd       = rocc_rd(bus.cmd_instr_i);

  // Live entries plus unpaid flush debt together bound the work in flight.
  assign w_total       = {1'b0, w_count} + {1'b0, r_drain};
  assign w_alloc_ready = (w_total < (CNT_W + 1)'(DEPTH));
  assign w_push_req    = bus.cmd_fire_i & rocc_xd(bus.cmd_instr_i);
  assign w_push        = w_push_req & w_alloc_ready;
  assign w_resp_fire   = bus.rocc_resp_valid_i;
  assign w_draining    = (r_drain != '0);
  assign w_rd_hit      = ~w_empty & (bus.rocc_resp_i.resp_rd == w_head.rd);

  always_comb begin
    w_fifo_push = w_push & ~flush_i;
    w_fifo_pop  = 1'b0;
    w_wb_fire   = 1'b0;
    w_mismatch  = 1'b0;
    w_debt      = r_drain + w_count + CNT_W'(w_push);
    w_drain_d   = r_drain;
    if (flush_i) begin
      // Everything in flight becomes debt; a same-cycle response pays one unit.
      if (w_resp_fire) begin
        if (w_debt != '0) w_debt = w_debt - CNT_W'(1);
        else              w_mismatch = 1'b1;
      end
      w_drain_d = w_debt;
    end else if (w_resp_fire) begin
      if (w_draining) begin
        w_drain_d = r_drain - CNT_W'(1);
      end else if (w_rd_hit) begin
        w_fifo_pop = 1'b1;
        w_wb_fire  = 1'b1;
      end else begin
        w_mismatch = 1'b1;
      end
    end
  end

  rocc_resp_tracker_tag_fifo #(
    .DEPTH (DEPTH),
    .W     (TAG_W),
    .CNT_W (CNT_W)
  ) u_tag_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .i_push  (w_fifo_push),
    .i_pop   (w_fifo_pop),
    .i_clear (flush_i),
    .i_wdata (w_push_tag),
    .o_head  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_drain       <= '0;
      r_wb_valid    <= 1'b0;
      r_wb_trans_id <= '0;
      r_wb_result   <= '0;
      r_mismatch    <= 1'b0;
    end else begin
      r_drain    <= w_drain_d;
      r_wb_valid <= w_wb_fire;
      r_mismatch <= w_mismatch;
      if (w_wb_fire) begin
        r_wb_trans_id <= w_head.trans_id;
        r_wb_result   <= bus.rocc_resp_i.resp_data;
      end
    end
  end

  assign bus.alloc_ready_o     = w_alloc_ready;
  assign bus.rocc_resp_ready_o = 1'b1;
  assign bus.wb_valid_o        = r_wb_valid;
  assign bus.wb_trans_id_o     = r_wb_trans_id;
  assign bus.wb_result_o       = r_wb_result;
  assign bus.wb_exception_o    = '0;
  assign outstanding_o         = w_count;
  assign drain_busy_o          = w_draining;
  assign rd_mismatch_o         = r_mismatch;

  // Issue must be gated by alloc_ready_o; a push past the limit is dropped.
  a_push_within_limit : assert property (
    @(posedge clk_i) disable iff (!rst_ni) w_push_req |-> w_alloc_ready
  );

  logic w_unused_full;
  assign w_unused_full = w_full;

endmodule
`default_nettype wire
